l2_req_noc_packetizer: RTL and testbench

L2_REQ_NOC_PACKETIZER -- requirements
Module: l2_req_noc_packetizer

---
 rtl/l2_req_noc_packetizer_pkg.sv | 44 ++++
 rtl/l2_req_noc_packetizer_word_select.sv | 33 +++
 rtl/l2_req_noc_packetizer.sv | 172 +++++++++++++++++
 tb/tb_l2_req_noc_packetizer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_req_noc_packetizer_pkg.sv
// Shared definitions for the L2 request packetizer: message codes, flit preambles,
// head-flit field offsets and the data-carrying message classifier.
`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 2
`endif

package l2_req_noc_packetizer_pkg;

    localparam int LINE_ADDR_BITS = 28;
    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [4:0] mix_msg_t;

    localparam mix_msg_t REQ_V     = 5'd0;
    localparam mix_msg_t REQ_S     = 5'd1;
    localparam mix_msg_t REQ_O     = 5'd2;
    localparam mix_msg_t REQ_Odata = 5'd3;
    localparam mix_msg_t REQ_WT    = 5'd4;
    localparam mix_msg_t REQ_WB    = 5'd5;
    localparam mix_msg_t REQ_WTfwd = 5'd6;

    localparam logic [1:0] PREAMBLE_HEADER = 2'b10;
    localparam logic [1:0] PREAMBLE_BODY   = 2'b00;
    localparam logic [1:0] PREAMBLE_TAIL   = 2'b01;

    localparam int SRC_Y_LSB     = 61;
    localparam int SRC_X_LSB     = 58;
    localparam int DST_Y_LSB     = 55;
    localparam int DST_X_LSB     = 52;
    localparam int COH_MSG_LSB   = 47;
    localparam int HPROT_LSB     = 45;
    localparam int WORD_MASK_MSB = 44;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        ADDR,
        DATA
    } pkt_state_e;

    function automatic logic msg_has_data(input mix_msg_t msg);
        return (msg == REQ_WT) || (msg == REQ_WB) || (msg == REQ_WTfwd);
    endfunction

endpackage

// File: rtl/l2_req_noc_packetizer_word_select.sv
// Finds the first data word at or after 'start' that must be sent. With
// L2_REQ_WORD_MASK_COMPACT_EN only masked-in words count; otherwise every word does.
module l2_req_word_select #(
    parameter int WPL   = 2,
    parameter int CNT_W = $clog2(WPL) + 1
) (
    input  logic [CNT_W-1:0] start,
    input  logic [WPL-1:0]   word_mask,
    output logic [CNT_W-1:0] word_idx,
    output logic             word_found
);

`ifdef L2_REQ_WORD_MASK_COMPACT_EN
    // Scan downwards so the lowest qualifying index is the one left standing.
    always_comb begin
        word_idx   = '0;
        word_found = 1'b0;
        for (int i = WPL - 1; i >= 0; i--) begin
            if ((i >= int'(start)) && word_mask[i]) begin
                word_idx   = CNT_W'(i);
                word_found = 1'b1;
            end
        end
    end
`else
    logic unused_word_mask;

    assign unused_word_mask = ^word_mask;
    assign word_idx         = start;
    assign word_found       = int'(start) < WPL;
`endif

endmodule

// File: rtl/l2_req_noc_packetizer.sv
// L2 request packetizer: one accepted request becomes head, address and optional data flits.
// Define L2_REQ_WORD_MASK_COMPACT_EN to send only the data words selected by word_mask.
`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 2
`endif

module l2_req_noc_packetizer
    import l2_req_noc_packetizer_pkg::*;
#(
    parameter int NOC_FLIT_SIZE = 66,
    parameter int WPL           = `WORDS_PER_LINE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      l2_req_out_valid,
    output logic                      l2_req_out_ready,
    input  logic [4:0]                coh_msg,
    input  logic [1:0]                hprot,
    input  logic [LINE_ADDR_BITS-1:0] addr,
    input  logic [WPL*64-1:0]         line,
    input  logic [WPL-1:0]            word_mask,
    input  logic [2:0]                dst_x,
    input  logic [2:0]                dst_y,
    input  logic [2:0]                src_x,
    input  logic [2:0]                src_y,
    output logic [NOC_FLIT_SIZE-1:0]  flit_out,
    output logic                      flit_valid,
    input  logic                      flit_ready,
    output logic                      busy
);

    localparam int CNT_W = $clog2(WPL) + 1;

    pkt_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4:0]                msg_q, msg_d;
    logic [1:0]                hprot_q, hprot_d;
    logic [LINE_ADDR_BITS-1:0] addr_q, addr_d;
    logic [WPL*64-1:0]         line_q, line_d;
    logic [WPL-1:0]            mask_q, mask_d;
    logic [2:0]                dst_x_q, dst_x_d;
    logic [2:0]                dst_y_q, dst_y_d;

    logic [CNT_W-1:0]          sel_start;
    logic [CNT_W-1:0]          sel_idx;
    logic                      sel_found;
    logic [1:0]                preamble;
    logic [63:0]               payload;

    // In ADDR the finder looks for the first word; in DATA it looks past the current one.
    assign sel_start = (state_q == DATA) ? cnt_q + CNT_W'(1) : '0;
    assign busy      = (state_q != IDLE);

    l2_req_word_select #(
        .WPL   (WPL),
        .CNT_W (CNT_W)
    ) u_word_select (
        .start      (sel_start),
        .word_mask  (mask_q),
        .word_idx   (sel_idx),
        .word_found (sel_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            msg_q   <= '0;
            hprot_q <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            mask_q  <= '0;
            dst_x_q <= '0;
            dst_y_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            hprot_q <= hprot_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            mask_q  <= mask_d;
            dst_x_q <= dst_x_d;
            dst_y_q <= dst_y_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        msg_d            = msg_q;
        hprot_d          = hprot_q;
        addr_d           = addr_q;
        line_d           = line_q;
        mask_d           = mask_q;
        dst_x_d          = dst_x_q;
        dst_y_d          = dst_y_q;
        l2_req_out_ready = 1'b0;
        flit_valid       = 1'b0;
        preamble         = PREAMBLE_BODY;
        payload          = '0;
        flit_out         = '0;

        case (state_q)
            IDLE: begin
                l2_req_out_ready = 1'b1;
                if (l2_req_out_valid) begin
                    msg_d   = coh_msg;
                    hprot_d = hprot;
                    addr_d  = addr;
                    line_d  = line;
                    mask_d  = word_mask;
                    dst_x_d = dst_x;
                    dst_y_d = dst_y;
                    cnt_d   = '0;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                flit_valid                       = 1'b1;
                preamble                         = PREAMBLE_HEADER;
                payload[SRC_Y_LSB +: 3]          = src_y;
                payload[SRC_X_LSB +: 3]          = src_x;
                payload[DST_Y_LSB +: 3]          = dst_y_q;
                payload[DST_X_LSB +: 3]          = dst_x_q;
                payload[COH_MSG_LSB +: 5]        = msg_q;
                payload[HPROT_LSB +: 2]          = hprot_q;
                payload[WORD_MASK_MSB -: WPL]    = mask_q;
                if (flit_ready) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // A data message whose mask selects nothing ends at the address flit.
                flit_valid                       = 1'b1;
                preamble                         = (msg_has_data(msg_q) && sel_found) ?
                                                   PREAMBLE_BODY : PREAMBLE_TAIL;
                payload[LINE_ADDR_BITS-1:0]      = addr_q;
                if (flit_ready) begin
                    if (msg_has_data(msg_q) && sel_found) begin
                        state_d = DATA;
                        cnt_d   = sel_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                flit_valid = 1'b1;
                preamble   = sel_found ? PREAMBLE_BODY : PREAMBLE_TAIL;
                payload    = line_q[int'(cnt_q)*64 +: 64];
                if (flit_ready) begin
                    if (sel_found) begin
                        cnt_d = sel_idx;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            flit_out[63:0]                 = payload;
            flit_out[NOC_FLIT_SIZE-1 -: 2] = preamble;
        end
    end

endmodule

// File: tb/tb_l2_req_noc_packetizer.sv
// Directed self-checking bench for l2_req_noc_packetizer (WPL=2); honours
// L2_REQ_WORD_MASK_COMPACT_EN when it is defined for the build.
module tb_l2_req_noc_packetizer;
    import l2_req_noc_packetizer_pkg::*;

    localparam int WPL = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              l2_req_out_valid = 1'b0;
    logic              l2_req_out_ready;
    logic [4:0]        coh_msg = '0;
    logic [1:0]        hprot = '0;
    logic [27:0]       addr = '0;
    logic [WPL*64-1:0] line = '0;
    logic [WPL-1:0]    word_mask = '0;
    logic [2:0]        dst_x = '0;
    logic [2:0]        dst_y = '0;
    logic [2:0]        src_x = 3'd1;
    logic [2:0]        src_y = 3'd2;
    logic [65:0]       flit_out;
    logic              flit_valid;
    logic              flit_ready = 1'b0;
    logic              busy;

    int                vectors = 0;
    int                miscompares = 0;
    logic [65:0]       flits[$];

    l2_req_noc_packetizer #(
        .NOC_FLIT_SIZE (66),
        .WPL           (WPL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .l2_req_out_valid (l2_req_out_valid),
        .l2_req_out_ready (l2_req_out_ready),
        .coh_msg          (coh_msg),
        .hprot            (hprot),
        .addr             (addr),
        .line             (line),
        .word_mask        (word_mask),
        .dst_x            (dst_x),
        .dst_y            (dst_y),
        .src_x            (src_x),
        .src_y            (src_y),
        .flit_out         (flit_out),
        .flit_valid       (flit_valid),
        .flit_ready       (flit_ready),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Record every flit the NoC accepts.
    always @(posedge clk) begin
        if (rst && flit_valid && flit_ready) flits.push_back(flit_out);
    end

    function automatic logic [65:0] flit_at(input int i);
        return (flits.size() > i) ? flits[i] : 66'hx;
    endfunction

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_req(input logic [4:0] msg, input logic [27:0] a, input logic [127:0] ln,
                            input logic [1:0] m, input logic [2:0] dx, input logic [2:0] dy,
                            input logic [1:0] hp);
        bit accepted = 0;
        @(negedge clk);
        coh_msg = msg; addr = a; line = ln; word_mask = m;
        dst_x = dx; dst_y = dy; hprot = hp;
        l2_req_out_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = l2_req_out_ready;
            @(posedge clk);
        end
        @(negedge clk);
        l2_req_out_valid = 1'b0;
        check("req_accepted", 66'(accepted), 66'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 66'(busy), 66'd0);
    endtask

    task automatic test_reset();
        #1;
        check("reset_flit_valid", 66'(flit_valid), 66'd0);
        check("reset_busy", 66'(busy), 66'd0);
        check("reset_flit_out", flit_out, 66'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 66'(l2_req_out_ready), 66'd1);
    endtask

    task automatic test_req_s();
        flits.delete();
        flit_ready = 1'b1;
        send_req(REQ_S, 28'h1234, '0, 2'b11, 3'd3, 3'd4, 2'b01);
        check("req_s_head_valid", 66'(flit_valid), 66'd1);
        check("req_s_head_preamble", 66'(flit_out[65:64]), 66'(2'b10));
        check("req_s_busy_ready", 66'({busy, l2_req_out_ready}), 66'(2'b10));
        @(negedge clk);
        check("req_s_addr_flit", flit_out, {2'b01, 64'h1234});
        @(negedge clk);
        check("req_s_idle_after", 66'({flit_valid, busy, l2_req_out_ready}), 66'(3'b001));
        check("req_s_flit_count", 66'(flits.size()), 66'd2);
    endtask

    task automatic test_head_fields();
        flits.delete();
        flit_ready = 1'b0;
        send_req(REQ_S, 28'h0042, '0, 2'b11, 3'd3, 3'd4, 2'b01);
        check("head_fields", flit_out, {2'b10, 64'h4630_B800_0000_0000});
        flit_ready = 1'b1;
        wait_idle(10);
    endtask

    task automatic test_wb();
        flits.delete();
        flit_ready = 1'b1;
        send_req(REQ_WB, 28'h0055, {64'hB, 64'hA}, 2'b11, 3'd1, 3'd1, 2'b00);
        wait_idle(20);
        check("wb_flit_count", 66'(flits.size()), 66'd4);
        check("wb_head_preamble", 66'(flit_at(0) >> 64), 66'(2'b10));
        check("wb_addr_flit", flit_at(1), {2'b00, 64'h55});
        check("wb_data0", flit_at(2), {2'b00, 64'hA});
        check("wb_data1", flit_at(3), {2'b01, 64'hB});
    endtask

    task automatic test_stall();
        bit          pattern [10] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1};
        logic [65:0] prev_flit = '0;
        bit          prev_stall = 0;
        int          k = 0;
        flits.delete();
        flit_ready = 1'b0;
        send_req(REQ_WB, 28'h0ABC, {64'hD, 64'hC}, 2'b11, 3'd5, 3'd6, 2'b10);
        while (busy && k < 40) begin
            if (prev_stall) check("stall_flit_stable", flit_out, prev_flit);
            prev_stall = flit_valid && !pattern[k % 10];
            prev_flit  = flit_out;
            flit_ready = pattern[k % 10];
            k++;
            @(negedge clk);
        end
        check("stall_idle", 66'(busy), 66'd0);
        check("stall_flit_count", 66'(flits.size()), 66'd4);
        check("stall_data0", flit_at(2), {2'b00, 64'hC});
        check("stall_data1", flit_at(3), {2'b01, 64'hD});
        flit_ready = 1'b1;
    endtask

    task automatic test_compaction();
        flits.delete();
        flit_ready = 1'b1;
        send_req(REQ_WT, 28'h0100, {64'h2B, 64'h1A}, 2'b10, 3'd2, 3'd2, 2'b00);
        wait_idle(20);
`ifdef L2_REQ_WORD_MASK_COMPACT_EN
        check("compact_flit_count", 66'(flits.size()), 66'd3);
        check("compact_addr_flit", flit_at(1), {2'b00, 64'h100});
        check("compact_only_data", flit_at(2), {2'b01, 64'h2B});
        flits.delete();
        send_req(REQ_WB, 28'h0200, {64'h2B, 64'h1A}, 2'b00, 3'd2, 3'd2, 2'b00);
        wait_idle(20);
        check("compact_nomask_count", 66'(flits.size()), 66'd2);
        check("compact_nomask_tail", flit_at(1), {2'b01, 64'h200});
`else
        check("full_flit_count", 66'(flits.size()), 66'd4);
        check("full_data0", flit_at(2), {2'b00, 64'h1A});
        check("full_data1", flit_at(3), {2'b01, 64'h2B});
`endif
    endtask

    task automatic test_reset_mid_packet();
        flits.delete();
        flit_ready = 1'b0;
        send_req(REQ_WB, 28'h0300, {64'hD, 64'hC}, 2'b11, 3'd1, 3'd2, 2'b00);
        flit_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flit_ready = 1'b0;
        @(negedge clk);
        check("midpkt_data_stalled", {flit_valid, flit_out[64:0]}, {1'b1, 1'b0, 64'hC});
        rst = 1'b0;
        #1;
        check("midpkt_reset_valid_busy", 66'({flit_valid, busy}), 66'd0);
        check("midpkt_reset_flit_out", flit_out, 66'd0);
        check("midpkt_flits_before", 66'(flits.size()), 66'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midpkt_ready_after", 66'(l2_req_out_ready), 66'd1);
        flits.delete();
        flit_ready = 1'b1;
        send_req(REQ_S, 28'h0077, '0, 2'b01, 3'd1, 3'd1, 2'b00);
        check("midpkt_new_head", 66'({flit_valid, flit_out[65:64]}), 66'(3'b110));
        wait_idle(10);
        check("midpkt_new_count", 66'(flits.size()), 66'd2);
        check("midpkt_new_tail", flit_at(1), {2'b01, 64'h77});
    endtask

    initial begin
        test_reset();
        test_req_s();
        test_head_fields();
        test_wb();
        test_stall();
        test_compaction();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
